// File: rtl/vacc_unit_if.sv
// Beat/result handshake bundle between the vector ALU, the accumulator stage and writeback.
interface vacc_unit_if #(
    parameter int unsigned CNT_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       v_i;
    logic [3:0]        over_i;
    logic [2:0]        ctrl_i;
    logic              first_i;
    logic              last_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       acc_o;
    logic              sat_o;
    logic [3:0]        sat_lanes_o;
    logic [3:0]        flags_o;
    logic [CNT_W-1:0]  beats_o;

    modport slave (
        input  in_valid_i, v_i, over_i, ctrl_i, first_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, acc_o, sat_o, sat_lanes_o, flags_o, beats_o
    );

    modport master (
        output in_valid_i, v_i, over_i, ctrl_i, first_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, acc_o, sat_o, sat_lanes_o, flags_o, beats_o
    );
endinterface

// File: rtl/vacc_unit.sv
// Vector accumulator: reduces a multi-beat ALU group into one result, using a scalar
// saturating sum for dot-product partials and per-byte-lane saturating sums for add/sub.
module vacc_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    vacc_unit_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam logic [CNT_W-1:0] BEATS_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    typedef enum logic [1:0] {MODE_PASS, MODE_SCALAR, MODE_LANE} mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d, mode_dec, mode_eff;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                sat_q, sat_d;
    logic [LANES-1:0]    sat_lanes_q, sat_lanes_d;
    logic [LANES-1:0]    flags_q, flags_d;
    logic [CNT_W-1:0]    beats_q, beats_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic                accept, opening;
    logic [DATA_W:0]     scalar_sum;
    logic                scalar_ovf;
    logic [DATA_W-1:0]   scalar_res;
    logic [LANE_W:0]     lane_sum [LANES];
    logic [DATA_W-1:0]   lane_res;
    logic [LANES-1:0]    lane_ovf;

    // Saturating adders for both reduction modes; clamp direction follows the true sign bit.
    always_comb begin
        scalar_sum = {acc_q[DATA_W-1], acc_q} + {bus.v_i[DATA_W-1], bus.v_i};
        scalar_ovf = scalar_sum[DATA_W] ^ scalar_sum[DATA_W-1];
        scalar_res = scalar_sum[DATA_W-1:0];
        if (scalar_ovf) begin
            scalar_res = scalar_sum[DATA_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        lane_res = '0;
        lane_ovf = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum[k] = {acc_q[k*LANE_W+LANE_W-1], acc_q[k*LANE_W +: LANE_W]}
                        + {bus.v_i[k*LANE_W+LANE_W-1], bus.v_i[k*LANE_W +: LANE_W]};
            lane_ovf[k] = lane_sum[k][LANE_W] ^ lane_sum[k][LANE_W-1];
            lane_res[k*LANE_W +: LANE_W] = lane_sum[k][LANE_W-1:0];
            if (lane_ovf[k]) begin
                lane_res[k*LANE_W +: LANE_W] = lane_sum[k][LANE_W] ? 8'h80 : 8'h7F;
            end
        end
    end

    always_comb begin
        case (bus.ctrl_i)
            3'b001:         mode_dec = MODE_SCALAR;
            3'b010, 3'b110: mode_dec = MODE_LANE;
            default:        mode_dec = MODE_PASS;
        endcase
    end

    // Next-state and datapath update; a beat is only taken while not holding a result.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        sat_lanes_d = sat_lanes_q;
        flags_d     = flags_q;
        beats_d     = beats_q;

        accept   = bus.in_valid_i & in_ready_q;
        opening  = accept & ((state_q == IDLE) | bus.first_i);
        mode_eff = opening ? mode_dec : mode_q;

        if (opening) begin
            mode_d      = mode_dec;
            acc_d       = bus.v_i;
            flags_d     = bus.over_i;
            beats_d     = CNT_W'(1);
            sat_d       = 1'b0;
            sat_lanes_d = '0;
        end else if (accept) begin
            flags_d = flags_q | bus.over_i;
            beats_d = (beats_q == BEATS_MAX) ? beats_q : beats_q + CNT_W'(1);
            if (mode_q == MODE_SCALAR) begin
                acc_d = scalar_res;
                sat_d = sat_q | scalar_ovf;
            end else if (mode_q == MODE_LANE) begin
                acc_d       = lane_res;
                sat_lanes_d = sat_lanes_q | lane_ovf;
                sat_d       = sat_q | (|lane_ovf);
            end
        end

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    state_d = (bus.last_i || mode_eff == MODE_PASS) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mode_q      <= MODE_PASS;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            sat_lanes_q <= '0;
            flags_q     <= '0;
            beats_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            sat_lanes_q <= sat_lanes_d;
            flags_q     <= flags_d;
            beats_q     <= beats_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.acc_o       = acc_q;
    assign bus.sat_o       = sat_q;
    assign bus.sat_lanes_o = sat_lanes_q;
    assign bus.flags_o     = flags_q;
    assign bus.beats_o     = beats_q;
endmodule

// File: tb/tb_vacc_unit.sv
// Directed bench for vacc_unit: scalar/lane reduction, saturation, backpressure, restart, reset.
module tb_vacc_unit;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    vacc_unit_if #(.CNT_W(8)) bus ();

    vacc_unit #(.CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a beat at a negedge, wait (bounded) for acceptance, return at the following negedge.
    task automatic send_beat(input logic [31:0] v, input logic [3:0] over,
                             input logic [2:0] ctrl, input logic first, input logic last);
        int waited;
        bit done;
        bus.v_i        = v;
        bus.over_i     = over;
        bus.ctrl_i     = ctrl;
        bus.first_i    = first;
        bus.last_i     = last;
        bus.in_valid_i = 1'b1;
        waited = 0;
        done   = 1'b0;
        while (!done && waited < 50) begin
            if (bus.in_ready_o === 1'b1) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        bus.in_valid_i = 1'b0;
        if (!done) begin
            $display("FAIL accept_timeout: in_ready_o never rose for beat %h", v);
            miscompares++;
            vectors++;
        end
    endtask

    task automatic take_result();
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        if (bus.in_ready_o !== 1'b1) begin $display("FAIL rst_in_ready got %b want 1", bus.in_ready_o); miscompares++; end
        vectors++;
        if (bus.out_valid_o !== 1'b0) begin $display("FAIL rst_out_valid got %b want 0", bus.out_valid_o); miscompares++; end
        vectors++;
        if ({bus.acc_o, bus.sat_o, bus.sat_lanes_o, bus.flags_o, bus.beats_o} !== 49'h0) begin
            $display("FAIL rst_outputs acc=%h sat=%b lanes=%b flags=%b beats=%0d want all zero",
                     bus.acc_o, bus.sat_o, bus.sat_lanes_o, bus.flags_o, bus.beats_o);
            miscompares++;
        end
        vectors++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_scalar();
        send_beat(32'h0000_0010, 4'b0000, 3'b001, 1'b1, 1'b0);
        send_beat(32'h0000_0020, 4'b0000, 3'b001, 1'b0, 1'b0);
        send_beat(32'hFFFF_FFF0, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.out_valid_o !== 1'b1) begin $display("FAIL scalar_valid got %b want 1", bus.out_valid_o); miscompares++; end
        vectors++;
        if (bus.acc_o !== 32'h0000_0020) begin $display("FAIL scalar_acc got %h want 00000020", bus.acc_o); miscompares++; end
        vectors++;
        if (bus.beats_o !== 8'd3) begin $display("FAIL scalar_beats got %0d want 3", bus.beats_o); miscompares++; end
        vectors++;
        if (bus.sat_o !== 1'b0) begin $display("FAIL scalar_sat got %b want 0", bus.sat_o); miscompares++; end
        vectors++;
        take_result();
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            $display("FAIL scalar_release valid=%b ready=%b want 0/1", bus.out_valid_o, bus.in_ready_o);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_scalar_sat();
        send_beat(32'h7FFF_FFF0, 4'b0000, 3'b001, 1'b1, 1'b0);
        send_beat(32'h0000_0100, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.acc_o !== 32'h7FFF_FFFF || bus.sat_o !== 1'b1) begin
            $display("FAIL scalar_pos_clamp acc=%h sat=%b want 7fffffff/1", bus.acc_o, bus.sat_o);
            miscompares++;
        end
        vectors++;
        take_result();
        send_beat(32'h8000_0000, 4'b0000, 3'b001, 1'b1, 1'b0);
        send_beat(32'hFFFF_FFFF, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.acc_o !== 32'h8000_0000 || bus.sat_o !== 1'b1) begin
            $display("FAIL scalar_neg_clamp acc=%h sat=%b want 80000000/1", bus.acc_o, bus.sat_o);
            miscompares++;
        end
        vectors++;
        if (bus.sat_lanes_o !== 4'b0000) begin $display("FAIL scalar_no_lanes got %b want 0000", bus.sat_lanes_o); miscompares++; end
        vectors++;
        take_result();
    endtask

    task automatic test_lane();
        send_beat(32'h7F01_807F, 4'b0001, 3'b010, 1'b1, 1'b0);
        send_beat(32'h01FF_FF81, 4'b0100, 3'b010, 1'b0, 1'b1);
        if (bus.acc_o !== 32'h7F00_8000) begin $display("FAIL lane_acc got %h want 7f008000", bus.acc_o); miscompares++; end
        vectors++;
        if (bus.sat_lanes_o !== 4'b1010) begin $display("FAIL lane_sat_lanes got %b want 1010", bus.sat_lanes_o); miscompares++; end
        vectors++;
        if (bus.sat_o !== 1'b1) begin $display("FAIL lane_sat got %b want 1", bus.sat_o); miscompares++; end
        vectors++;
        if (bus.flags_o !== 4'b0101) begin $display("FAIL lane_flags got %b want 0101", bus.flags_o); miscompares++; end
        vectors++;
        take_result();
    endtask

    task automatic test_backpressure();
        send_beat(32'h0000_0005, 4'b0000, 3'b001, 1'b1, 1'b1);
        bus.v_i = 32'h0000_0007; bus.over_i = 4'b0000; bus.ctrl_i = 3'b001;
        bus.first_i = 1'b1; bus.last_i = 1'b1; bus.in_valid_i = 1'b1;
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.acc_o !== 32'h0000_0005
                || bus.beats_o !== 8'd1) begin
                $display("FAIL bp_hold cyc=%0d ready=%b valid=%b acc=%h beats=%0d want 0/1/00000005/1",
                         c, bus.in_ready_o, bus.out_valid_o, bus.acc_o, bus.beats_o);
                miscompares++;
            end
            vectors++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            $display("FAIL bp_release ready=%b valid=%b want 1/0", bus.in_ready_o, bus.out_valid_o);
            miscompares++;
        end
        vectors++;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== 32'h0000_0007) begin
            $display("FAIL bp_held_beat valid=%b acc=%h want 1/00000007", bus.out_valid_o, bus.acc_o);
            miscompares++;
        end
        vectors++;
        take_result();
    endtask

    task automatic test_restart();
        send_beat(32'h0000_0100, 4'b0010, 3'b001, 1'b1, 1'b0);
        send_beat(32'h0000_0200, 4'b0000, 3'b001, 1'b0, 1'b0);
        send_beat(32'h0000_0005, 4'b0000, 3'b001, 1'b1, 1'b0);
        send_beat(32'h0000_0006, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.acc_o !== 32'h0000_000B || bus.beats_o !== 8'd2 || bus.flags_o !== 4'b0000) begin
            $display("FAIL restart acc=%h beats=%0d flags=%b want 0000000b/2/0000",
                     bus.acc_o, bus.beats_o, bus.flags_o);
            miscompares++;
        end
        vectors++;
        take_result();
        send_beat(32'hDEAD_BEEF, 4'b1000, 3'b000, 1'b0, 1'b0);
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== 32'hDEAD_BEEF || bus.beats_o !== 8'd1) begin
            $display("FAIL passthrough valid=%b acc=%h beats=%0d want 1/deadbeef/1",
                     bus.out_valid_o, bus.acc_o, bus.beats_o);
            miscompares++;
        end
        vectors++;
        take_result();
    endtask

    task automatic test_beats_sat();
        send_beat(32'h0000_0000, 4'b0000, 3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 258; i++) send_beat(32'h0000_0000, 4'b0000, 3'b001, 1'b0, 1'b0);
        send_beat(32'h0000_0001, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.beats_o !== 8'd255 || bus.acc_o !== 32'h0000_0001) begin
            $display("FAIL beats_sat beats=%0d acc=%h want 255/00000001", bus.beats_o, bus.acc_o);
            miscompares++;
        end
        vectors++;
        take_result();
    endtask

    task automatic test_async_reset();
        send_beat(32'h0000_0011, 4'b0001, 3'b001, 1'b1, 1'b0);
        send_beat(32'h0000_0022, 4'b0000, 3'b001, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        if (bus.acc_o !== 32'h0 || bus.beats_o !== 8'd0 || bus.flags_o !== 4'b0 || bus.in_ready_o !== 1'b1) begin
            $display("FAIL rst_in_acc acc=%h beats=%0d flags=%b ready=%b want 0/0/0/1",
                     bus.acc_o, bus.beats_o, bus.flags_o, bus.in_ready_o);
            miscompares++;
        end
        vectors++;
        #1 rst = 1'b0;
        @(negedge clk);
        send_beat(32'h0000_0033, 4'b0000, 3'b110, 1'b1, 1'b1);
        if (bus.out_valid_o !== 1'b1) begin $display("FAIL pre_hold_rst valid=%b want 1", bus.out_valid_o); miscompares++; end
        vectors++;
        bus.out_ready_i = 1'b1;
        rst = 1'b1;
        #1;
        if (bus.out_valid_o !== 1'b0 || bus.acc_o !== 32'h0 || bus.in_ready_o !== 1'b1) begin
            $display("FAIL rst_in_hold valid=%b acc=%h ready=%b want 0/0/1",
                     bus.out_valid_o, bus.acc_o, bus.in_ready_o);
            miscompares++;
        end
        vectors++;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b0) begin $display("FAIL rst_no_emit valid=%b want 0", bus.out_valid_o); miscompares++; end
            vectors++;
        end
        bus.out_ready_i = 1'b0;
        send_beat(32'h0000_0003, 4'b0000, 3'b001, 1'b0, 1'b1);
        if (bus.acc_o !== 32'h0000_0003 || bus.beats_o !== 8'd1 || bus.out_valid_o !== 1'b1) begin
            $display("FAIL post_rst_group acc=%h beats=%0d valid=%b want 00000003/1/1",
                     bus.acc_o, bus.beats_o, bus.out_valid_o);
            miscompares++;
        end
        vectors++;
        take_result();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.v_i = '0;
        bus.over_i = '0;
        bus.ctrl_i = '0;
        bus.first_i = 1'b0;
        bus.last_i = 1'b0;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_scalar();
        test_scalar_sat();
        test_lane();
        test_backpressure();
        test_restart();
        test_beats_sat();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
